fetch_line_ctrl: RTL
====================

Name: fetch_line_ctrl

Overview:
- Sequences instruction fetch between the frontend, the single-line fetch buffer and the I-cache read port.
- Demand fetches that hit the buffered line are served from the buffer.
- Misses issue one line read to the I-cache, refill the buffer, then return the requested word.
- Handles pipeline flushes with an outstanding miss and keeps hit/miss performance counters.

Parameters:
- LINE_BITS, 256, line width in bits; fixed at 256 (8 words, 32-byte line).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fetch_req  in  1  frontend fetch request, sampled only when fetch_ready=1
- fetch_addr  in  32  byte address of the instruction; bits[1:0] ignored
- fetch_ready  out  1  controller can accept a request this cycle
- fetch_resp  out  1  one-cycle pulse: fetch_rdata valid
- fetch_rdata  out  32  returned instruction word
- fetch_resp_addr  out  32  word-aligned address of the returned word
- flush  in  1  kill the in-flight fetch (redirect)
- linebuffer_line  in  256  buffered line
- linebuffer_addr  in  32  buffered line address
- linebuffer_valid  in  1  buffer holds a line
- lb_fill  out  1  one-cycle pulse: buffer captures lb_fill_line and lb_fill_addr
- lb_fill_line  out  256  refill data
- lb_fill_addr  out  32  refill line address, bits[4:0]=0
- icache_req  out  1  line read request, held until icache_resp
- icache_addr  out  32  line-aligned read address
- icache_rdata  in  256  returned line
- icache_resp  in  1  one-cycle pulse: icache_rdata valid
- perf_hits  out  CNT_W  accepted requests that hit the buffer
- perf_misses  out  CNT_W  accepted requests that missed

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - fetch_resp, lb_fill and icache_req are 0.
  - fetch_rdata, fetch_resp_addr, icache_addr, lb_fill_addr and lb_fill_line are 0.
  - Counters are 0.
  - A reset during MISS_WAIT or DISCARD abandons the miss. A later icache_resp in IDLE is ignored.
- Hit test: linebuffer_valid && linebuffer_addr[31:5]==fetch_addr[31:5]. Word select is fetch_addr[4:2]; word k = bits[32k+31:32k].
- States: IDLE, MISS_WAIT, DISCARD.
- fetch_ready=1 only in IDLE.
- IDLE, fetch_req=1, flush=0, hit:
  - Next cycle: fetch_resp=1, fetch_rdata = selected word, fetch_resp_addr = {fetch_addr[31:2],2'b00}.
  - perf_hits += 1.
  - Remain IDLE, so back-to-back hits give 1 response per cycle.
- IDLE, fetch_req=1, flush=0, miss:
  - Latch the address. Next cycle: icache_req=1, icache_addr = {fetch_addr[31:5],5'b0}.
  - perf_misses += 1. Go to MISS_WAIT.
- IDLE, flush=1: the request is not accepted and no counter changes. A fetch_resp already scheduled for next cycle is suppressed.
- MISS_WAIT:
  - icache_req and icache_addr are held stable.
  - On icache_resp (registered outputs, one cycle later):
    - lb_fill=1, lb_fill_line=icache_rdata, lb_fill_addr=latched line address.
    - fetch_resp=1, fetch_rdata = word[latched addr[4:2]] of icache_rdata, not of the buffer.
  - icache_req drops in the cycle after icache_resp. Return to IDLE.
  - Miss latency: 1 cycle to request, plus I-cache latency, plus 1 cycle to response.
- MISS_WAIT with flush=1 and no icache_resp: go to DISCARD and keep icache_req held.
- DISCARD: on icache_resp, do the lb_fill exactly as in MISS_WAIT but no fetch_resp; go to IDLE. flush in DISCARD has no further effect.
- flush and icache_resp in the same cycle (MISS_WAIT): fill the buffer, suppress fetch_resp, go to IDLE.
- Buffer refill is visible to the hit test in the cycle after lb_fill. The request arriving in the cycle lb_fill/fetch_resp are asserted (state IDLE) must use the buffer's registered content. The refill must not cause a duplicate response.
- Counters wrap modulo 2^CNT_W and are not cleared by flush.
- icache_resp outside MISS_WAIT/DISCARD is ignored.

Test Plan:
- Reset, then buffer valid with addr 0x0000_1000, line word3=0xDEAD_BEEF; request 0x0000_100C -> next cycle fetch_resp=1, fetch_rdata=0xDEAD_BEEF, fetch_resp_addr=0x100C, perf_hits=1.
- Request 0x0000_2024, buffer at 0x1000 -> icache_req=1, icache_addr=0x2020. After 3-cycle cache latency, icache_resp with word1=0x1234_5678 -> lb_fill with lb_fill_addr=0x2020 and fetch_rdata=0x1234_5678 one cycle later; perf_misses=1.
- 8 back-to-back hit requests 0x1000..0x101C -> 8 consecutive fetch_resp cycles in order; fetch_ready stays 1.
- Miss to 0x3000, flush 2 cycles later, icache_resp later -> lb_fill with addr 0x3000, no fetch_resp, then IDLE with fetch_ready=1.
- flush coincident with icache_resp -> lb_fill=1, fetch_resp=0; flush coincident with a hit request -> no response, perf_hits unchanged.
- Assert rst during MISS_WAIT, then stray icache_resp -> all outputs 0, no lb_fill, counters 0; wrap test with CNT_W=4: 16 hits -> perf_hits=0.

Source files
------------

// File: rtl/fetch_line_ctrl.sv
// Fetch sequencer between the frontend, a single-line fetch buffer and the I-cache.
// Hits are answered from the buffer; misses read one line, refill the buffer and return the word.
module fetch_line_ctrl #(
  parameter int LINE_BITS = 256,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_req,
  input  logic [31:0]          fetch_addr,
  output logic                 fetch_ready,
  output logic                 fetch_resp,
  output logic [31:0]          fetch_rdata,
  output logic [31:0]          fetch_resp_addr,
  input  logic                 flush,
  input  logic [LINE_BITS-1:0] linebuffer_line,
  input  logic [31:0]          linebuffer_addr,
  input  logic                 linebuffer_valid,
  output logic                 lb_fill,
  output logic [LINE_BITS-1:0] lb_fill_line,
  output logic [31:0]          lb_fill_addr,
  output logic                 icache_req,
  output logic [31:0]          icache_addr,
  input  logic [LINE_BITS-1:0] icache_rdata,
  input  logic                 icache_resp,
  output logic [CNT_W-1:0]     perf_hits,
  output logic [CNT_W-1:0]     perf_misses
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] MISS_WAIT = 2'd1;
  localparam logic [1:0] DISCARD   = 2'd2;

  logic [1:0]  state;
  logic [31:0] miss_addr;
  logic        hit;
  logic        accept;
  logic [31:0] hit_data;
  logic [31:0] miss_data;

  assign fetch_ready = (state == IDLE);
  assign accept      = fetch_ready && fetch_req && !flush;
  assign hit         = linebuffer_valid && (linebuffer_addr[31:5] == fetch_addr[31:5]);
  assign hit_data    = linebuffer_line[{fetch_addr[4:2], 5'b00000} +: 32];
  // The missed word comes straight from the returning line, not from the buffer.
  assign miss_data   = icache_rdata[{miss_addr[4:2], 5'b00000} +: 32];

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      miss_addr       <= '0;
      fetch_resp      <= 1'b0;
      fetch_rdata     <= '0;
      fetch_resp_addr <= '0;
      lb_fill         <= 1'b0;
      lb_fill_line    <= '0;
      lb_fill_addr    <= '0;
      icache_req      <= 1'b0;
      icache_addr     <= '0;
      perf_hits       <= '0;
      perf_misses     <= '0;
    end else begin
      fetch_resp <= 1'b0;
      lb_fill    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (hit) begin
              fetch_resp      <= 1'b1;
              fetch_rdata     <= hit_data;
              fetch_resp_addr <= {fetch_addr[31:2], 2'b00};
              perf_hits       <= perf_hits + CNT_W'(1);
            end else begin
              miss_addr   <= {fetch_addr[31:2], 2'b00};
              icache_req  <= 1'b1;
              icache_addr <= {fetch_addr[31:5], 5'b00000};
              perf_misses <= perf_misses + CNT_W'(1);
              state       <= MISS_WAIT;
            end
          end
        end
        MISS_WAIT, DISCARD: begin
          if (icache_resp) begin
            lb_fill      <= 1'b1;
            lb_fill_line <= icache_rdata;
            lb_fill_addr <= {miss_addr[31:5], 5'b00000};
            icache_req   <= 1'b0;
            state        <= IDLE;
            // A flush that lands with the response still refills but drops the word.
            if (state == MISS_WAIT && !flush) begin
              fetch_resp      <= 1'b1;
              fetch_rdata     <= miss_data;
              fetch_resp_addr <= miss_addr;
            end
          end else if (state == MISS_WAIT && flush) begin
            state <= DISCARD;
          end
        end
        default: begin
          icache_req <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
